// File: rtl/fifo_upsizing.sv
`default_nettype none
// ============================================================================
// Module   : fifo_upsizing
// Brief    : Packs narrow beats into wide words and queues them in a FIFO
//            with a registered wide-side read port.
// Revision : 1.0
// ============================================================================
module fifo_upsizing #(
    parameter int MEM_DEPTH           = 16,
    parameter int DATA_WIDTH_IN       = 32,
    parameter int DATA_WIDTH_OUT      = 128,
    parameter int EXTRA_DATA_WIDTH    = 8,
    parameter int NEARLY_FULL_THRESH  = 12,
    parameter int NEARLY_EMPTY_THRESH = 2,
    localparam int RATIO              = DATA_WIDTH_OUT / DATA_WIDTH_IN,
    localparam int DST_W              = $clog2(RATIO)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [DST_W-1:0]                           wr_dst,
    input  logic                                       wr_en,
    input  logic                                       wr_commit,
    input  logic [DATA_WIDTH_IN+EXTRA_DATA_WIDTH-1:0]  data_in,
    input  logic                                       rd_en,
    output logic [DATA_WIDTH_OUT+EXTRA_DATA_WIDTH-1:0] data_out,
    output logic [RATIO-1:0]                           lane_valid_out,
    output logic [RATIO-1:0]                           pack_lanes,
    output logic                                       fifo_full,
    output logic                                       fifo_empty,
    output logic                                       fifo_nearly_full,
    output logic                                       fifo_nearly_empty,
    output logic                                       fifo_one_from_full
);

    // Tiny depths collapse to a fixed 4-entry FIFO with fixed thresholds.
    localparam bit SMALL        = ($clog2(MEM_DEPTH) < 2);
    localparam int FIFO_SIZE    = SMALL ? 4 : MEM_DEPTH;
    localparam int NEARLY_FULL  = SMALL ? 3 : NEARLY_FULL_THRESH;
    localparam int NEARLY_EMPTY = SMALL ? 1 : NEARLY_EMPTY_THRESH;
    localparam int PTR_W        = $clog2(FIFO_SIZE);
    localparam int CNT_W        = $clog2(FIFO_SIZE + 1);
    localparam int WORD_W       = DATA_WIDTH_OUT + EXTRA_DATA_WIDTH;
    localparam int ENTRY_W      = WORD_W + RATIO;

    localparam logic [CNT_W-1:0] C_FULL_CNT  = CNT_W'(FIFO_SIZE);
    localparam logic [CNT_W-1:0] C_OFF_CNT   = CNT_W'(FIFO_SIZE - 1);
    localparam logic [CNT_W-1:0] C_NF_CNT    = CNT_W'(NEARLY_FULL);
    localparam logic [CNT_W-1:0] C_NE_CNT    = CNT_W'(NEARLY_EMPTY);
    localparam logic [PTR_W-1:0] C_PTR_LAST  = PTR_W'(FIFO_SIZE - 1);
    localparam logic [DST_W-1:0] C_LAST_LANE = DST_W'(RATIO - 1);

    logic [ENTRY_W-1:0]          mem_q [FIFO_SIZE];
    logic [PTR_W-1:0]            wrptr_q, wrptr_d;
    logic [PTR_W-1:0]            rdptr_q, rdptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [DATA_WIDTH_OUT-1:0]   pack_q, pack_d;
    logic [RATIO-1:0]            pack_lanes_q, pack_lanes_d;
    logic [WORD_W-1:0]           data_out_q, data_out_d;
    logic [RATIO-1:0]            lane_valid_q, lane_valid_d;

    logic [DATA_WIDTH_IN-1:0]    w_beat;
    logic [EXTRA_DATA_WIDTH-1:0] w_extra;
    logic [DATA_WIDTH_OUT-1:0]   w_merged_word;
    logic [RATIO-1:0]            w_merged_lanes;
    logic                        w_acc;
    logic                        w_commit;
    logic                        w_pop;

    assign w_beat   = data_in[DATA_WIDTH_IN-1:0];
    assign w_extra  = data_in[DATA_WIDTH_IN +: EXTRA_DATA_WIDTH];
    assign w_acc    = wr_en & ~fifo_full;
    assign w_commit = w_acc & (wr_commit | (wr_dst == C_LAST_LANE));
    assign w_pop    = rd_en & ~fifo_empty;

    // The committed word must include the beat arriving this cycle.
    always_comb begin
        w_merged_word                                      = pack_q;
        w_merged_word[wr_dst*DATA_WIDTH_IN +: DATA_WIDTH_IN] = w_beat;
        w_merged_lanes                                     = pack_lanes_q;
        w_merged_lanes[wr_dst]                             = 1'b1;
    end

    always_comb begin
        pack_d       = pack_q;
        pack_lanes_d = pack_lanes_q;
        wrptr_d      = wrptr_q;
        rdptr_d      = rdptr_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        lane_valid_d = lane_valid_q;

        if (w_commit) begin
            pack_d       = '0;
            pack_lanes_d = '0;
            wrptr_d      = (wrptr_q == C_PTR_LAST) ? '0 : wrptr_q + PTR_W'(1);
        end else if (w_acc) begin
            pack_d       = w_merged_word;
            pack_lanes_d = w_merged_lanes;
        end

        if (w_pop) begin
            {data_out_d, lane_valid_d} = mem_q[rdptr_q];
            rdptr_d = (rdptr_q == C_PTR_LAST) ? '0 : rdptr_q + PTR_W'(1);
        end

        case ({w_commit, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrptr_q      <= '0;
            rdptr_q      <= '0;
            count_q      <= '0;
            pack_q       <= '0;
            pack_lanes_q <= '0;
            data_out_q   <= '0;
            lane_valid_q <= '0;
        end else begin
            wrptr_q      <= wrptr_d;
            rdptr_q      <= rdptr_d;
            count_q      <= count_d;
            pack_q       <= pack_d;
            pack_lanes_q <= pack_lanes_d;
            data_out_q   <= data_out_d;
            lane_valid_q <= lane_valid_d;
        end
    end

    // Storage carries no reset; only entries behind a commit are ever read.
    always_ff @(posedge clk) begin
        if (rst && w_commit) begin
            mem_q[wrptr_q] <= {w_extra, w_merged_word, w_merged_lanes};
        end
    end

    assign data_out           = data_out_q;
    assign lane_valid_out     = lane_valid_q;
    assign pack_lanes         = pack_lanes_q;
    assign fifo_full          = (count_q == C_FULL_CNT);
    assign fifo_empty         = (count_q == '0);
    assign fifo_nearly_full   = (count_q >= C_NF_CNT);
    assign fifo_nearly_empty  = (count_q <= C_NE_CNT);
    assign fifo_one_from_full = (count_q == C_OFF_CNT);

endmodule
`default_nettype wire

// File: tb/tb_fifo_upsizing.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_upsizing
// Brief    : Directed stimulus with a queue scoreboard for fifo_upsizing.
// Revision : 1.0
// ============================================================================
module tb_fifo_upsizing;

    localparam int ENT_W = 8 + 128 + 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   wr_dst = '0;
    logic         wr_en = 1'b0;
    logic         wr_commit = 1'b0;
    logic [39:0]  data_in = '0;
    logic         rd_en = 1'b0;
    logic [135:0] data_out;
    logic [3:0]   lane_valid_out;
    logic [3:0]   pack_lanes;
    logic         fifo_full, fifo_empty, fifo_nearly_full, fifo_nearly_empty, fifo_one_from_full;

    fifo_upsizing dut (
        .clk                (clk),
        .rst                (rst),
        .wr_dst             (wr_dst),
        .wr_en              (wr_en),
        .wr_commit          (wr_commit),
        .data_in            (data_in),
        .rd_en              (rd_en),
        .data_out           (data_out),
        .lane_valid_out     (lane_valid_out),
        .pack_lanes         (pack_lanes),
        .fifo_full          (fifo_full),
        .fifo_empty         (fifo_empty),
        .fifo_nearly_full   (fifo_nearly_full),
        .fifo_nearly_empty  (fifo_nearly_empty),
        .fifo_one_from_full (fifo_one_from_full)
    );

    always #5 clk = ~clk;

    int                 n_cmp  = 0;
    int                 n_fail = 0;
    bit                 pop_req = 1'b0;
    logic [ENT_W-1:0]   exp_q[$];
    logic [ENT_W-1:0]   mq[$];
    logic [127:0]       m_pack = '0;
    logic [3:0]         m_lanes = '0;

    task automatic chk(input string name, input logic [ENT_W-1:0] act, input logic [ENT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Flags order: full, empty, nearly_full, nearly_empty, one_from_full.
    task automatic chk_flags(input string name);
        int c;
        logic [4:0] e;
        c = mq.size();
        e = {c == 16, c == 0, c >= 12, c <= 2, c == 15};
        chk(name, ENT_W'({fifo_full, fifo_empty, fifo_nearly_full,
                          fifo_nearly_empty, fifo_one_from_full}), ENT_W'(e));
    endtask

    // Drive one cycle from a negedge and advance the model in step with it.
    task automatic step(input bit en, input int dst, input logic [31:0] beat,
                        input logic [7:0] ext, input bit cm, input bit rd);
        logic [127:0] tmp;
        logic [3:0]   tl;
        bit           acc, pop;
        wr_en     = en;
        wr_dst    = dst[1:0];
        data_in   = {ext, beat};
        wr_commit = cm;
        rd_en     = rd;
        acc = en && (mq.size() != 16);
        pop = rd && (mq.size() != 0);
        if (pop) begin
            exp_q.push_back(mq.pop_front());
            pop_req = 1'b1;
        end
        if (acc) begin
            tmp = m_pack;
            tmp[dst*32 +: 32] = beat;
            tl = m_lanes;
            tl[dst] = 1'b1;
            if (cm || dst == 3) begin
                mq.push_back({ext, tmp, tl});
                m_pack  = '0;
                m_lanes = '0;
            end else begin
                m_pack  = tmp;
                m_lanes = tl;
            end
        end
        @(negedge clk);
        wr_en     = 1'b0;
        wr_commit = 1'b0;
        rd_en     = 1'b0;
        pop_req   = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b1;
        mq.delete();
        m_pack  = '0;
        m_lanes = '0;
    endtask

    // Monitor: each cycle that carried a pop, compare the registered output.
    initial begin
        forever begin
            @(posedge clk);
            if (pop_req) begin
                #1;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL pop_data: got %h expected <no entry queued>", {data_out, lane_valid_out});
                end else begin
                    chk("pop_data", {data_out, lane_valid_out}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        do_reset(3);
        repeat (5) @(negedge clk);
        chk_flags("reset_flags");
        chk("reset_data_out", ENT_W'({data_out, lane_valid_out}), '0);
        chk("reset_pack_lanes", ENT_W'(pack_lanes), '0);

        // Full four-lane word, auto-committed by lane 3.
        step(1, 0, 32'h11111111, 8'hA5, 0, 0);
        chk("pack_after_lane0", ENT_W'(pack_lanes), ENT_W'(4'b0001));
        step(1, 1, 32'h22222222, 8'hA5, 0, 0);
        step(1, 2, 32'h33333333, 8'hA5, 0, 0);
        chk("pack_after_lane2", ENT_W'(pack_lanes), ENT_W'(4'b0111));
        step(1, 3, 32'h44444444, 8'hA5, 0, 0);
        chk("pack_after_commit", ENT_W'(pack_lanes), '0);
        chk_flags("flags_one_word");
        step(0, 0, '0, '0, 0, 1);
        chk("full_word", {data_out, lane_valid_out},
            {8'hA5, 128'h44444444_33333333_22222222_11111111, 4'b1111});

        // Single-lane explicit commit.
        step(1, 1, 32'hDEADBEEF, 8'h3C, 1, 0);
        step(0, 0, '0, '0, 0, 1);
        chk("partial_word", {data_out, lane_valid_out},
            {8'h3C, 128'h00000000_00000000_DEADBEEF_00000000, 4'b0010});
        step(0, 0, '0, '0, 0, 1);
        chk("rd_empty_holds", {data_out, lane_valid_out},
            {8'h3C, 128'h00000000_00000000_DEADBEEF_00000000, 4'b0010});
        chk_flags("flags_empty_again");

        // Fill to 16 with no reads, checking every threshold crossing.
        for (int i = 0; i < 16; i++) begin
            step(1, i % 4, 32'h10000000 + i, 8'(i), 1, 0);
            chk_flags("flags_fill");
        end
        chk("full_hand", ENT_W'({fifo_full, fifo_nearly_full, fifo_one_from_full}), ENT_W'(3'b110));
        step(1, 0, 32'hFFFF0000, 8'hEE, 0, 0);
        chk("full_beat_ignored", ENT_W'(pack_lanes), '0);
        chk_flags("flags_full_hold");

        // Pop and committing beat together at full: pop wins, beat is held.
        step(1, 2, 32'hCAFE0001, 8'h77, 1, 1);
        chk("one_from_full_hand", ENT_W'({fifo_full, fifo_one_from_full}), ENT_W'(2'b01));
        step(1, 2, 32'hCAFE0001, 8'h77, 1, 0);
        chk("refull_hand", ENT_W'(fifo_full), ENT_W'(1'b1));

        // Drain with one simultaneous commit+pop midway; wraps the pointers.
        for (int i = 0; i < 17; i++) begin
            step(i == 5, 1, 32'hBEEF0000 + i, 8'h5A, 1, 1);
            if (i == 5) chk_flags("flags_commit_and_pop");
        end
        chk_flags("flags_drained");
        chk("empty_hand", ENT_W'({fifo_empty, fifo_nearly_empty}), ENT_W'(2'b11));

        // Reset mid-packing discards the partial word.
        step(1, 0, 32'hAAAA0000, 8'h11, 0, 0);
        step(1, 2, 32'hAAAA0002, 8'h11, 0, 0);
        chk("pack_before_reset", ENT_W'(pack_lanes), ENT_W'(4'b0101));
        do_reset(1);
        chk("pack_after_reset", ENT_W'(pack_lanes), '0);
        chk("data_after_reset", ENT_W'({data_out, lane_valid_out}), '0);
        chk_flags("flags_after_reset");
        step(1, 3, 32'h0BADF00D, 8'h81, 0, 0);
        step(0, 0, '0, '0, 0, 1);
        chk("post_reset_word", {data_out, lane_valid_out},
            {8'h81, 128'h0BADF00D_00000000_00000000_00000000, 4'b1000});

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", ENT_W'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
